// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS front end: reset/exception PCs,
// the NOP encoding, fetch FSM states and IF/ID register operations.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP            = 32'h0000_0000;

  typedef enum logic {
    RUN        = 1'b0,
    WAIT_REDIR = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    ID_HOLD  = 2'd0,
    ID_LOAD  = 2'd1,
    ID_SKID  = 2'd2,
    ID_FLUSH = 2'd3
  } id_op_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold/load/flush, plus the one-entry skid that
// parks a word fetched while decode is stalled.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  id_op_e      op_i,
  input  logic        skid_wr_i,
  input  logic        skid_clr_i,
  input  logic [31:0] f_instr_i,
  input  logic [31:0] f_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        skid_vld_o
);

  logic [31:0] instr_q, pc_q, pc_plus4_q;
  logic        valid_q;
  logic        skid_vld_q;
  logic [31:0] skid_instr_q, skid_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (op_i)
        ID_LOAD: begin
          instr_q    <= f_instr_i;
          pc_q       <= f_pc_i;
          pc_plus4_q <= pc_inc(f_pc_i);
          valid_q    <= 1'b1;
        end
        ID_SKID: begin
          instr_q    <= skid_instr_q;
          pc_q       <= skid_pc_q;
          pc_plus4_q <= pc_inc(skid_pc_q);
          valid_q    <= 1'b1;
        end
        ID_FLUSH: begin
          instr_q <= NOP;
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      skid_vld_q <= 1'b0;
    else if (skid_clr_i)
      skid_vld_q <= 1'b0;
    else if (skid_wr_i)
      skid_vld_q <= 1'b1;
  end

  // Skid payload is only meaningful while skid_vld_q is set.
  always_ff @(posedge clk) begin
    if (skid_wr_i) begin
      skid_instr_q <= f_instr_i;
      skid_pc_q    <= f_pc_i;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
  assign skid_vld_o = skid_vld_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem req/ready handshake, picks the
// next PC and feeds decode through the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  input  logic        eret,
  input  logic [31:0] eret_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_q, redir_d;
  logic         skid_vld;
  logic         redirect;
  logic [31:0]  target;
  id_op_e       id_op;
  logic         skid_wr, skid_clr;

  assign imem_req  = !reset && !skid_vld;
  assign imem_addr = pc_q;
  assign redirect  = exc | eret | br_taken | jump;

  always_comb begin
    target = jump_target;
    if (exc)           target = EXC_VECTOR;
    else if (eret)     target = eret_pc;
    else if (br_taken) target = br_target;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    id_op    = ID_HOLD;
    skid_wr  = 1'b0;
    skid_clr = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          id_op    = ID_FLUSH;
          skid_clr = 1'b1;
          // An outstanding request must keep its address until memory answers.
          if (imem_req && !imem_ready) begin
            redir_d = target;
            state_d = WAIT_REDIR;
          end else begin
            pc_d = target;
          end
        end else if (skid_vld) begin
          if (!stall) begin
            id_op    = ID_SKID;
            skid_clr = 1'b1;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc(pc_q);
          if (stall) skid_wr = 1'b1;
          else       id_op   = ID_LOAD;
        end else if (!stall) begin
          id_op = ID_FLUSH;
        end
      end
      WAIT_REDIR: begin
        id_op = ID_FLUSH;
        if (redirect) redir_d = target;
        if (imem_ready) begin
          pc_d    = redirect ? target : redir_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .op_i       (id_op),
    .skid_wr_i  (skid_wr),
    .skid_clr_i (skid_clr),
    .f_instr_i  (imem_rdata),
    .f_pc_i     (pc_q),
    .instr_o    (instr_id),
    .pc_o       (pc_id),
    .pc_plus4_o (pc_plus4_id),
    .valid_o    (valid_id),
    .skid_vld_o (skid_vld)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the fetch scenarios, then random
// traffic against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jump, exc, eret, imem_ready;
  logic [31:0] br_target, jump_target, eret_pc;
  logic        imem_req, valid_id;
  logic [31:0] imem_addr, imem_rdata, instr_id, pc_id, pc_plus4_id;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_redir, m_instr, m_pcid, m_sk_instr, m_sk_pc;
  logic        m_vld, m_wait, m_skid;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  assign imem_rdata = imem_ready ? memw(imem_addr) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target),
    .exc(exc), .eret(eret), .eret_pc(eret_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_id(instr_id), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id),
    .valid_id(valid_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_redir = '0; m_wait = 1'b0; m_skid = 1'b0;
    m_vld = 1'b0; m_instr = '0; m_pcid = '0;
  endtask

  // One clock of the fetch rules, applied to the inputs present this cycle.
  task automatic model_step();
    logic        req, redir;
    logic [31:0] tgt;
    if (reset) begin
      model_reset();
      return;
    end
    req   = !m_skid;
    redir = exc | eret | br_taken | jump;
    tgt   = exc ? 32'h0000_4180 : eret ? eret_pc : br_taken ? br_target : jump_target;
    if (m_wait) begin
      m_vld = 1'b0; m_instr = '0;
      if (redir) m_redir = tgt;
      if (imem_ready) begin m_pc = m_redir; m_wait = 1'b0; end
    end else if (redir) begin
      m_vld = 1'b0; m_instr = '0; m_skid = 1'b0;
      if (req && !imem_ready) begin m_wait = 1'b1; m_redir = tgt; end
      else m_pc = tgt;
    end else if (m_skid) begin
      if (!stall) begin
        m_vld = 1'b1; m_instr = m_sk_instr; m_pcid = m_sk_pc; m_skid = 1'b0;
      end
    end else if (imem_ready) begin
      if (stall) begin m_skid = 1'b1; m_sk_instr = memw(m_pc); m_sk_pc = m_pc; end
      else begin m_vld = 1'b1; m_instr = memw(m_pc); m_pcid = m_pc; end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_vld = 1'b0; m_instr = '0;
    end
  endtask

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  // Compare DUT against model mid-cycle, advance model, cross the clock edge.
  task automatic tick();
    logic exp_req;
    @(negedge clk);
    exp_req = !reset && !m_skid;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    if (prev_pend && !reset) chk("addr_stable", imem_addr, prev_addr);
    chk("valid_id", valid_id, m_vld);
    if (m_vld) begin
      chk("instr_id", instr_id, m_instr);
      chk("pc_id", pc_id, m_pcid);
      chk("pc_plus4_id", pc_plus4_id, m_pcid + 32'd4);
    end else begin
      chk("bubble_instr", instr_id, 32'h0);
    end
    prev_pend = exp_req && !imem_ready;
    prev_addr = imem_addr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0; exc = 1'b0;
    eret = 1'b0; imem_ready = 1'b0;
    br_target = '0; jump_target = '0; eret_pc = '0;
    model_reset();
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_valid", valid_id, 1'b0);
    chk("rst_pc_id", pc_id, 32'h0);

    // Zero-wait sequential fetch
    reset = 1'b0; imem_ready = 1'b1;
    chk("first_addr", imem_addr, 32'h0000_3000);
    tick();
    chk("seq_pc_id", pc_id, 32'h0000_3000);
    chk("seq_valid", valid_id, 1'b1);
    chk("seq_pc4", pc_plus4_id, 32'h0000_3004);
    chk("seq_addr", imem_addr, 32'h0000_3004);

    // Wait states hold the address and give bubbles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", imem_addr, 32'h0000_3004);
      chk("wait_valid", valid_id, 1'b0);
    end
    imem_ready = 1'b1;
    tick();
    chk("wait_pc_id", pc_id, 32'h0000_3004);
    chk("wait_instr", instr_id, memw(32'h0000_3004));

    // Branch while a request is outstanding
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3100;
    tick();
    br_taken = 1'b0;
    tick();
    chk("redir_hold_addr", imem_addr, 32'h0000_3008);
    imem_ready = 1'b1;
    tick();
    chk("redir_addr", imem_addr, 32'h0000_3100);
    chk("redir_valid", valid_id, 1'b0);

    // Stall captures the completing fetch in the skid
    tick();
    stall = 1'b1;
    tick();
    chk("stall_req", imem_req, 1'b0);
    chk("stall_pc_id", pc_id, 32'h0000_3100);
    stall = 1'b0;
    tick();
    chk("skid_pc_id", pc_id, 32'h0000_3104);
    chk("skid_valid", valid_id, 1'b1);
    chk("skid_resume", imem_addr, 32'h0000_3108);

    // exc beats a simultaneous branch
    exc = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3200;
    tick();
    exc = 1'b0; br_taken = 1'b0;
    chk("exc_addr", imem_addr, 32'h0000_4180);
    chk("exc_valid", valid_id, 1'b0);

    eret = 1'b1; eret_pc = 32'h0000_3040;
    tick();
    eret = 1'b0;
    chk("eret_addr", imem_addr, 32'h0000_3040);
    tick();
    chk("eret_pc_id", pc_id, 32'h0000_3040);

    // PC wrap at the top of the address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_id, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom % 128) == 0;
      stall       = ($urandom % 4) == 0;
      imem_ready  = ($urandom % 3) != 0;
      exc         = ($urandom % 24) == 0;
      eret        = ($urandom % 24) == 0;
      br_taken    = ($urandom % 10) == 0;
      jump        = ($urandom % 10) == 0;
      br_target   = $urandom & 32'hFFFF_FFFC;
      jump_target = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                          : ($urandom & 32'hFFFF_FFFC);
      eret_pc     = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
